rgb_binarizer_adaptive: RTL and testbench
=========================================

Name: rgb_binarizer_adaptive

Overview:
Parametrised successor to the fixed-threshold binarizer in the camera RGB pipeline, sitting between the Bayer-to-RGB stage and the SDRAM/VGA writer. It converts each pixel to black or white in one of four modes: pass-through, per-channel threshold, gray threshold with a fixed level, or gray threshold with an adaptive level. The adaptive level is the mean gray of the first 2^LOG2_NPIX pixels of the previous frame. The block is a 2-stage pipeline with a frame-level accumulator; mode and threshold are updated only at frame boundaries.

Parameters:
DW, 12, pixel channel width in bits.
LOG2_NPIX, 16, log2 of the number of pixels averaged per frame for the adaptive threshold.
HYST, 64, hysteresis half-band in gray LSBs (used only with the optional feature).

Ports:
iCLK  in  1  clock; all logic on rising edge.
iRST_n  in  1  asynchronous active-low reset.
iFrameStart  in  1  single-cycle pulse marking the first cycle of a frame.
iDVAL  in  1  input pixel valid.
iRed  in  DW  red channel.
iGreen  in  DW  green channel.
iBlue  in  DW  blue channel.
iMode  in  2  0 pass-through, 1 per-channel threshold, 2 gray fixed, 3 gray adaptive.
iTh  in  DW  fixed threshold for modes 1 and 2.
oDVAL  out  1  output pixel valid.
oRed  out  DW  output red.
oGreen  out  DW  output green.
oBlue  out  DW  output blue.
oTh  out  DW  threshold currently in force.
oAdaptValid  out  1  high once at least one full 2^LOG2_NPIX sample has completed.

Behaviour:
- Reset (async, iRST_n low): all outputs 0 except oTh = 2^(DW-1). Adaptive level = 2^(DW-1). Accumulator, pixel counter and mode register = 0. Pipeline valids = 0.
- Gray: g = (R + 2G + B) >> 2. Computed at DW+2 bits, result DW bits, no overflow possible.
- Pipeline, stage 1: register R, G, B, g and iDVAL.
- Pipeline, stage 2: compare and register outputs.
- Latency is exactly 2 cycles: oDVAL(t+2) = iDVAL(t). The pipeline is not stalled by iDVAL.
- When oDVAL = 0, the colour outputs hold their last value.
- Mode/threshold latch: iMode and iTh are sampled into internal registers on an iFrameStart cycle only. Mid-frame changes are ignored until the next iFrameStart.
- Adaptive level update: also on iFrameStart, the adaptive level takes sum >> LOG2_NPIX if the counter saturated in the frame just ended; otherwise the previous level is kept.
- Effective threshold th: mode 3 uses the adaptive level; modes 1 and 2 use the latched iTh. oTh = th and updates on the same edge.
- Mode 0: outputs = inputs, delayed 2 cycles.
- Mode 1: each channel independently outputs 2^DW-1 if the channel value > th, else 0.
- Modes 2 and 3: all three channels output 2^DW-1 if g > th, else 0. The comparison is strictly greater-than, so g == th gives black.
- Accumulator: counts gray values of iDVAL pixels while the counter < 2^LOG2_NPIX. Sum width is DW+LOG2_NPIX. Pixels beyond the sample are ignored.
- iFrameStart clears the sum and counter. If iFrameStart and iDVAL are high together, that pixel is the first sample of the new frame (the sum is loaded with g, the counter with 1).
- oAdaptValid: set on the first iFrameStart that follows a saturated sample; cleared only by reset.
- Short frame (fewer than 2^LOG2_NPIX valid pixels): adaptive level unchanged, oAdaptValid unchanged.
- Reset mid-frame: everything returns to reset values immediately. The first output after reset uses the reset mode (0) until iFrameStart.

Optional Feature:
Macro BINARIZE_HYST_EN applies to modes 2 and 3 only.
- Defined: output white if g > th+HYST, black if g < th-HYST. Inside the band, repeat the previous binary decision.
- th±HYST saturates to [0, 2^DW-1].
- The previous decision resets to black on reset and on iFrameStart.
- Not defined: plain strict comparison; HYST unused; no extra state.

Test Plan:
- Reset then iFrameStart with iMode=0, pixel (100,200,300) -> same pixel on outputs 2 cycles later, oDVAL aligned, oTh=2048.
- iMode=1, iTh=2048, pixel (2049,2048,4095) -> (4095,0,4095).
- iMode=2, iTh=1000, R=G=B=1000 -> black; R=G=B=1001 -> white. Change iTh to 0 mid-frame -> no effect until next iFrameStart.
- LOG2_NPIX=4, iMode=3: frame of 16 pixels with g=512, then iFrameStart -> oTh=512, oAdaptValid=1. The next frame's g=513 gives white, g=512 gives black.
- LOG2_NPIX=4: a frame of only 10 pixels at g=100 -> oTh keeps its previous value (512), oAdaptValid unchanged. iFrameStart with iDVAL together -> that pixel is counted in the new frame.
- BINARIZE_HYST_EN, HYST=64, th=1000: g sequence 1065, 1000, 935, 1000 -> white, white, black, black. iRST_n low mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rgb_binarizer_adaptive.sv
// Adaptive RGB binarizer: pass-through, per-channel, fixed-gray or
// adaptive-gray thresholding behind a 2-stage pixel pipeline. The adaptive
// level is the mean gray of the first 2^LOG2_NPIX valid pixels of the
// previous frame. Mode and threshold change only on iFrameStart.
// Optional hysteresis on the gray modes: define BINARIZE_HYST_EN.
module rgb_binarizer_adaptive #(
  parameter int DW        = 12,
  parameter int LOG2_NPIX = 16,
  parameter int HYST      = 64
) (
  input  logic          iCLK,
  input  logic          iRST_n,
  input  logic          iFrameStart,
  input  logic          iDVAL,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic [1:0]    iMode,
  input  logic [DW-1:0] iTh,
  output logic          oDVAL,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic [DW-1:0] oTh,
  output logic          oAdaptValid
);

  localparam int SW = DW + LOG2_NPIX;
  localparam logic [DW-1:0]      MID     = {1'b1, {(DW-1){1'b0}}};
  localparam logic [LOG2_NPIX:0] CNT_ONE = {{LOG2_NPIX{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_CHAN  = 2'd1,
    MODE_GRAY  = 2'd2,
    MODE_ADAPT = 2'd3
  } mode_t;

  // A half-band of 2^DW or more would make the clamped band meaningless.
  if ((HYST < 0) || (HYST >= (1 << DW))) begin : g_bad_hyst
    $error("HYST must lie in [0, 2^DW-1]");
  end

  mode_t              mode_q;
  logic [DW-1:0]      th_fix_q;
  logic [DW-1:0]      adapt_lvl;
  logic               adapt_valid;
  logic [SW-1:0]      sum_q;
  logic [LOG2_NPIX:0] cnt_q;
  logic [DW+1:0]      gray_wide;
  logic [DW-1:0]      gray_in;
  logic [SW-1:0]      gray_ext;
  logic [DW-1:0]      th;

  logic [DW-1:0]      r_s1, g_s1, b_s1, gray_s1;
  logic               dval_s1;
  logic               gray_white;
  logic [DW-1:0]      bin_r, bin_g, bin_b;

`ifdef BINARIZE_HYST_EN
  localparam logic [DW:0] HYST_W = (DW+1)'(HYST);
  logic [DW:0]   th_hi_w;
  logic [DW-1:0] band_hi, band_lo;
  logic          prev_white;
`endif

  // Gray of the incoming pixel, full precision before the divide by 4
  always_comb begin
    gray_wide = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
    gray_in   = gray_wide[DW+1:2];
    gray_ext  = {{LOG2_NPIX{1'b0}}, gray_in};
  end

  // Threshold in force follows the latched mode
  always_comb begin
    th = (mode_q == MODE_ADAPT) ? adapt_lvl : th_fix_q;
  end

  assign oTh         = th;
  assign oAdaptValid = adapt_valid;

  // Mode and fixed threshold are latched only at frame start
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      mode_q   <= MODE_PASS;
      th_fix_q <= MID;
    end else if (iFrameStart) begin
      mode_q   <= mode_t'(iMode);
      th_fix_q <= iTh;
    end
  end

  // Frame accumulator; a pixel arriving with iFrameStart opens the new sample
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sum_q       <= '0;
      cnt_q       <= '0;
      adapt_lvl   <= MID;
      adapt_valid <= 1'b0;
    end else if (iFrameStart) begin
      if (cnt_q[LOG2_NPIX]) begin
        adapt_lvl   <= sum_q[SW-1:LOG2_NPIX];
        adapt_valid <= 1'b1;
      end
      sum_q <= iDVAL ? gray_ext : '0;
      cnt_q <= {{LOG2_NPIX{1'b0}}, iDVAL};
    end else if (iDVAL && !cnt_q[LOG2_NPIX]) begin
      sum_q <= sum_q + gray_ext;
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Stage 1: register the pixel, its gray value and the valid flag
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_s1    <= '0;
      g_s1    <= '0;
      b_s1    <= '0;
      gray_s1 <= '0;
      dval_s1 <= 1'b0;
    end else begin
      r_s1    <= iRed;
      g_s1    <= iGreen;
      b_s1    <= iBlue;
      gray_s1 <= gray_in;
      dval_s1 <= iDVAL;
    end
  end

  // Gray decision: strict compare, or hysteresis band clamped to the pixel range
  always_comb begin
`ifdef BINARIZE_HYST_EN
    th_hi_w = {1'b0, th} + HYST_W;
    band_hi = th_hi_w[DW] ? '1 : th_hi_w[DW-1:0];
    band_lo = ({1'b0, th} < HYST_W) ? '0 : (th - HYST_W[DW-1:0]);
    if (gray_s1 > band_hi)      gray_white = 1'b1;
    else if (gray_s1 < band_lo) gray_white = 1'b0;
    else                        gray_white = prev_white;
`else
    gray_white = (gray_s1 > th);
`endif
  end

`ifdef BINARIZE_HYST_EN
  // Remembered gray decision; frame start wins over the pixel leaving stage 2
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      prev_white <= 1'b0;
    end else if (iFrameStart) begin
      prev_white <= 1'b0;
    end else if (dval_s1 && mode_q[1]) begin
      prev_white <= gray_white;
    end
  end
`endif

  // Per-mode binarization of the stage-1 pixel
  always_comb begin
    bin_r = r_s1;
    bin_g = g_s1;
    bin_b = b_s1;
    unique case (mode_q)
      MODE_PASS: ;
      MODE_CHAN: begin
        bin_r = {DW{r_s1 > th}};
        bin_g = {DW{g_s1 > th}};
        bin_b = {DW{b_s1 > th}};
      end
      default: begin
        bin_r = {DW{gray_white}};
        bin_g = {DW{gray_white}};
        bin_b = {DW{gray_white}};
      end
    endcase
  end

  // Stage 2: valid always advances, colours hold while no pixel is valid
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oDVAL  <= 1'b0;
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
    end else begin
      oDVAL <= dval_s1;
      if (dval_s1) begin
        oRed   <= bin_r;
        oGreen <= bin_g;
        oBlue  <= bin_b;
      end
    end
  end

endmodule

// File: tb/tb_rgb_binarizer_adaptive.sv
// Bench for rgb_binarizer_adaptive (DW=12, LOG2_NPIX=4, HYST=64).
module tb_rgb_binarizer_adaptive;

  localparam int DW   = 12;
  localparam int L2   = 4;
  localparam int HYST = 64;
  localparam int NPIX = 16;
  localparam int MAXV = 4095;

`ifdef BINARIZE_HYST_EN
  localparam int E1001 = 0;     // 1001 sits inside the band around 1000
  localparam int E0AT0 = MAXV;  // 0 vs th 0 is inside the band, previous was white
  localparam int E513  = 0;
`else
  localparam int E1001 = MAXV;
  localparam int E0AT0 = 0;
  localparam int E513  = MAXV;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fs, dv;
  logic [DW-1:0] r, g, b, th;
  logic [1:0]    mode;
  logic          o_dv, o_av;
  logic [DW-1:0] o_r, o_g, o_b, o_th;

  rgb_binarizer_adaptive #(.DW(DW), .LOG2_NPIX(L2), .HYST(HYST)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iFrameStart(fs), .iDVAL(dv),
    .iRed(r), .iGreen(g), .iBlue(b), .iMode(mode), .iTh(th),
    .oDVAL(o_dv), .oRed(o_r), .oGreen(o_g), .oBlue(o_b),
    .oTh(o_th), .oAdaptValid(o_av)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_mode, m_fix, m_lvl, m_av, m_prev;
  int frame_q[$];
  int e_dv, e_r, e_g, e_b;

  typedef struct {
    int fs, dv, r, g, b, mode, th;
    int er, eg, eb, edv, eth;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int rr, input int gg, input int bb);
    return (rr + 2 * gg + bb) / 4;
  endfunction

  function automatic int m_th();
    return (m_mode == 3) ? m_lvl : m_fix;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fix = 2048; m_lvl = 2048; m_av = 0; m_prev = 0;
    frame_q.delete();
    e_dv = 0; e_r = 0; e_g = 0; e_b = 0;
  endtask

  // One clock of stimulus; checks the outputs that this edge produces
  task automatic step(input int f, input int v, input int rr, input int gg,
                      input int bb, input int md, input int t);
    int n_dv, n_r, n_g, n_b, gy, thn, white, s;
`ifdef BINARIZE_HYST_EN
    int hi, lo;
`endif
    @(negedge clk);
    fs = f[0]; dv = v[0];
    r = rr[DW-1:0]; g = gg[DW-1:0]; b = bb[DW-1:0];
    mode = md[1:0]; th = t[DW-1:0];
    if (f != 0) begin
      if (frame_q.size() >= NPIX) begin
        s = 0;
        for (int i = 0; i < NPIX; i++) s += frame_q[i];
        m_lvl = s / NPIX;
        m_av  = 1;
      end
      frame_q.delete();
      m_mode = md; m_fix = t; m_prev = 0;
    end
    gy = gray_of(rr, gg, bb);
    if (v != 0) frame_q.push_back(gy);
    n_dv = v; n_r = e_r; n_g = e_g; n_b = e_b;
    if (v != 0) begin
      thn = m_th();
      if (m_mode == 0) begin
        n_r = rr; n_g = gg; n_b = bb;
      end else if (m_mode == 1) begin
        n_r = (rr > thn) ? MAXV : 0;
        n_g = (gg > thn) ? MAXV : 0;
        n_b = (bb > thn) ? MAXV : 0;
      end else begin
`ifdef BINARIZE_HYST_EN
        hi = (thn + HYST > MAXV) ? MAXV : thn + HYST;
        lo = (thn - HYST < 0) ? 0 : thn - HYST;
        if (gy > hi)      white = 1;
        else if (gy < lo) white = 0;
        else              white = m_prev;
        m_prev = white;
`else
        white = (gy > thn) ? 1 : 0;
`endif
        n_r = white ? MAXV : 0; n_g = n_r; n_b = n_r;
      end
    end
    @(posedge clk); #1;
    chk("oDVAL", o_dv, e_dv);
    chk("oRed", o_r, e_r);
    chk("oGreen", o_g, e_g);
    chk("oBlue", o_b, e_b);
    chk("oTh", o_th, m_th());
    chk("oAdaptValid", o_av, m_av);
    e_dv = n_dv; e_r = n_r; e_g = n_g; e_b = n_b;
  endtask

  task automatic chk_vec(input int j);
    chk("tbl_dval", o_dv, vt[j].edv);
    if (vt[j].edv != 0) begin
      chk("tbl_red", o_r, vt[j].er);
      chk("tbl_green", o_g, vt[j].eg);
      chk("tbl_blue", o_b, vt[j].eb);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fs = 1'b0; dv = 1'b0;
    r = '0; g = '0; b = '0; th = '0; mode = '0;
    model_reset();

    vt[0] = '{1, 1,  100,  200,  300, 0, 2048,  100,  200,  300, 1, 2048};
    vt[1] = '{0, 0,    0,    0,    0, 0,    0,    0,    0,    0, 0, 2048};
    vt[2] = '{1, 1, 2049, 2048, 4095, 1, 2048, MAXV,    0, MAXV, 1, 2048};
    vt[3] = '{1, 1, 1000, 1000, 1000, 2, 1000,    0,    0,    0, 1, 1000};
    vt[4] = '{0, 1, 1001, 1001, 1001, 2,    0, E1001, E1001, E1001, 1, 1000};
    vt[5] = '{0, 1,  500,  500,  500, 2,    0,    0,    0,    0, 1, 1000};
    vt[6] = '{1, 1,  500,  500,  500, 2,    0, MAXV, MAXV, MAXV, 1,    0};
    vt[7] = '{0, 1,    0,    0,    0, 2,    0, E0AT0, E0AT0, E0AT0, 1,   0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_oDVAL", o_dv, 0);
    chk("reset_oRed", o_r, 0);
    chk("reset_oGreen", o_g, 0);
    chk("reset_oBlue", o_b, 0);
    chk("reset_oTh", o_th, 2048);
    chk("reset_oAdaptValid", o_av, 0);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      step(vt[i].fs, vt[i].dv, vt[i].r, vt[i].g, vt[i].b, vt[i].mode, vt[i].th);
      chk("tbl_oTh", o_th, vt[i].eth);
      if (i > 0) chk_vec(i - 1);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk_vec(7);

    // Adaptive level from a full 16-pixel frame at gray 512
    step(1, 1, 512, 512, 512, 3, 0);
    chk("adapt_pre_th", o_th, 2048);
    for (int i = 0; i < NPIX - 1; i++) step(0, 1, 512, 512, 512, 0, 0);
    step(1, 0, 0, 0, 0, 3, 0);
    chk("adapt_th", o_th, 512);
    chk("adapt_valid", o_av, 1);
    step(0, 1, 513, 513, 513, 0, 0);
    step(0, 1, 512, 512, 512, 0, 0);
    chk("adapt_513", o_r, E513);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("adapt_512", o_r, 0);

    // Short frame keeps the level; the pixel with iFrameStart opens the next sample
    for (int i = 0; i < 10; i++) step(0, 1, 100, 100, 100, 0, 0);
    step(1, 1, 100, 100, 100, 3, 0);
    chk("short_th", o_th, 512);
    chk("short_valid", o_av, 1);
    for (int i = 0; i < NPIX - 1; i++) step(0, 1, 200, 200, 200, 0, 0);
    step(1, 0, 0, 0, 0, 3, 0);
    chk("fs_pixel_counted_th", o_th, 193);

`ifdef BINARIZE_HYST_EN
    step(1, 1, 1065, 1065, 1065, 2, 1000);
    step(0, 1, 1000, 1000, 1000, 0, 0);
    chk("hyst_1065", o_r, MAXV);
    step(0, 1, 935, 935, 935, 0, 0);
    chk("hyst_1000a", o_r, MAXV);
    step(0, 1, 1000, 1000, 1000, 0, 0);
    chk("hyst_935", o_r, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hyst_1000b", o_r, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 29) == 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)),
           int'($urandom_range(0, MAXV)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, MAXV)));
    end

    // Asynchronous reset in the middle of a cycle
    step(1, 1, 4095, 4095, 4095, 0, 3000);
    step(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_oDVAL", o_dv, 0);
    chk("async_oRed", o_r, 0);
    chk("async_oGreen", o_g, 0);
    chk("async_oBlue", o_b, 0);
    chk("async_oTh", o_th, 2048);
    chk("async_oAdaptValid", o_av, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(0, 1, 10, 20, 30, 2, 500);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_pass", o_r, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
